// File: rtl/game_pkg.sv
// Shared types and widths for the factorization game: state codes, counter widths and
// the result-state helper used by the controller and the input/display blocks.
package game_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned LIFE_W  = 3;
  localparam int unsigned TIMER_W = 6;
  localparam int unsigned PHASE_W = 6;

  typedef enum logic [3:0] {
    StIdle     = 4'b0000,
    StFetch    = 4'b0010,
    StQuestion = 4'b0011,
    StInput    = 4'b0100,
    StJudge    = 4'b0101,
    StDraw     = 4'b0110,
    StGood     = 4'b1000,
    StOuch     = 4'b1001,
    StWin      = 4'b1010,
    StLose     = 4'b1011
  } state_e;

  function automatic logic is_result(state_e s);
    return s inside {StDraw, StGood, StOuch, StWin, StLose};
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the round sequencer and its environment (board keys, question source,
// judge and the input/display block).
interface game_ctrl_if;
  import game_pkg::*;

  logic               START;
  logic               TICK;
  logic               QUE_OK;
  logic               DEC;
  logic               RES_VALID;
  logic               RES_OK;
  logic [3:0]         STATE;
  logic               Q_REQ;
  logic [SCORE_W-1:0] SCORE;
  logic [LIFE_W-1:0]  LIFE;
  logic [TIMER_W-1:0] TIMER;

  // The sequencer side.
  modport master (
    input  START, TICK, QUE_OK, DEC, RES_VALID, RES_OK,
    output STATE, Q_REQ, SCORE, LIFE, TIMER
  );

  // The environment side.
  modport slave (
    output START, TICK, QUE_OK, DEC, RES_VALID, RES_OK,
    input  STATE, Q_REQ, SCORE, LIFE, TIMER
  );

endinterface

// File: rtl/tick_timer.sv
// Loadable down-counter stepped by a qualified tick; zero flags the tick that expires it.
module tick_timer #(
  parameter int unsigned W = 6
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt  = cnt_q;
  // Load wins over en, so a tick on the loading cycle is never counted.
  assign zero = en && (cnt_q <= W'(1));

endmodule

// File: rtl/game_ctrl.sv
// Round sequencer: fetches questions, times the answer window, collects verdicts and
// tracks score/lives until WIN or LOSE.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned TIME_LIMIT   = 30,
  parameter int unsigned SHOW_TICKS   = 2,
  parameter int unsigned RESULT_TICKS = 2
) (
  input logic         CLK,
  input logic         RST,
  game_ctrl_if.master bus
);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIFE_W-1:0]  life_q, life_d;
  logic               entry_q;

  logic               phase_load, phase_en, phase_done;
  logic [PHASE_W-1:0] phase_len;
  logic [PHASE_W-1:0] unused_phase_cnt;
  logic               timer_load, timer_en, timer_done;
  logic [TIMER_W-1:0] timer_cnt;

  assign phase_load = (state_d != state_q);
  assign phase_en   = bus.TICK && (state_q inside {StQuestion, StDraw, StGood, StOuch});
  assign timer_load = (state_q == StQuestion) && (state_d == StInput);
  // DEC takes priority over a coincident timeout tick.
  assign timer_en   = bus.TICK && (state_q == StInput) && !bus.DEC;

  always_comb begin
    phase_len = '0;
    case (state_d)
      StQuestion:             phase_len = PHASE_W'(SHOW_TICKS);
      StDraw, StGood, StOuch: phase_len = PHASE_W'(RESULT_TICKS);
      default:                phase_len = '0;
    endcase
  end

  tick_timer #(.W(PHASE_W)) u_phase (
    .CLK      (CLK),
    .RST      (RST),
    .load     (phase_load),
    .load_val (phase_len),
    .en       (phase_en),
    .cnt      (unused_phase_cnt),
    .zero     (phase_done)
  );

  tick_timer #(.W(TIMER_W)) u_answer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (timer_load),
    .load_val (TIMER_W'(TIME_LIMIT)),
    .en       (timer_en),
    .cnt      (timer_cnt),
    .zero     (timer_done)
  );

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    life_d  = life_q;
    case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d = StFetch;
          score_d = '0;
          life_d  = LIFE_W'(LIVES);
        end
      end
      // QUE_OK on the first FETCH cycle is left over from the previous question.
      StFetch:    if (bus.QUE_OK && !entry_q) state_d = StQuestion;
      StQuestion: if (phase_done) state_d = StInput;
      StInput: begin
        if (bus.DEC) begin
          state_d = StJudge;
        end else if (timer_done) begin
          state_d = StDraw;
          life_d  = (life_q == '0) ? '0 : life_q - LIFE_W'(1);
        end
      end
      StJudge: begin
        if (bus.RES_VALID) begin
          if (bus.RES_OK) begin
            state_d = StGood;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
          end else begin
            state_d = StOuch;
            life_d  = (life_q == '0) ? '0 : life_q - LIFE_W'(1);
          end
        end
      end
      StDraw, StGood, StOuch: begin
        if (phase_done) begin
          if (score_q == SCORE_W'(WIN_SCORE)) state_d = StWin;
          else if (life_q == '0)              state_d = StLose;
          else                                state_d = StFetch;
        end
      end
      StWin, StLose: if (bus.START) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      score_q <= '0;
      life_q  <= '0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      life_q  <= life_d;
      entry_q <= (state_d != state_q);
    end
  end

  assign bus.STATE = state_q;
  assign bus.Q_REQ = (state_q == StFetch);
  assign bus.SCORE = score_q;
  assign bus.LIFE  = life_q;
  assign bus.TIMER = (state_q inside {StInput, StDraw}) ? timer_cnt : '0;

endmodule
